// File: rtl/mmio_bus_fabric.sv
// Memory-mapped bus fabric between the picorv32 native memory port and NUM_TARGETS targets.
// Decodes an address prefix per slot, holds chip-select until ready, and aborts on timeout.
module mmio_bus_fabric #(
  parameter int                                  NUM_TARGETS     = 8,
  parameter int                                  PREFIX_WIDTH    = 8,
  parameter logic [NUM_TARGETS*PREFIX_WIDTH-1:0] TARGET_PREFIXES = '0,
  parameter int                                  TIMEOUT_CYCLES  = 255,
  parameter logic [31:0]                         ERR_DATA        = 32'hdeadbeef,
  parameter logic [31:0]                         TRAP_DATA       = 32'h0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_valid,
  input  logic [31:0]               cpu_addr,
  input  logic [31:0]               cpu_wdata,
  input  logic [3:0]                cpu_wstrb,
  output logic                      cpu_ready,
  output logic [31:0]               cpu_rdata,
  input  logic                      force_trap,
  output logic [NUM_TARGETS-1:0]    tgt_cs,
  output logic [3:0]                tgt_we,
  output logic [23:0]               tgt_addr,
  output logic [31:0]               tgt_wdata,
  input  logic [NUM_TARGETS*32-1:0] tgt_rdata,
  input  logic [NUM_TARGETS-1:0]    tgt_ready,
  input  logic                      error_clear,
  output logic                      bus_error,
  output logic [31:0]               error_addr
);

  localparam int IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wstrb_q;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    // Scan downwards so the lowest matching slot is the one left standing.
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (TARGET_PREFIXES[i*PREFIX_WIDTH +: PREFIX_WIDTH] == cpu_addr[31 -: PREFIX_WIDTH]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign tgt_we    = wstrb_q & {4{|tgt_cs}};
  assign tgt_addr  = addr_q[23:0];
  assign tgt_wdata = wdata_q;

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx_q      <= '0;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      tgt_cs     <= '0;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      bus_error  <= 1'b0;
      error_addr <= '0;
    end else begin
      cpu_ready <= 1'b0;
      // A clear is overridden by any error raised later in this block.
      if (error_clear) bus_error <= 1'b0;

      case (state)
        IDLE: begin
          if (cpu_valid && !cpu_ready) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            wstrb_q <= cpu_wstrb;
            if (force_trap) begin
              state     <= RESP;
              cpu_ready <= 1'b1;
              cpu_rdata <= TRAP_DATA;
            end else if (!hit) begin
              state      <= RESP;
              cpu_ready  <= 1'b1;
              cpu_rdata  <= '0;
              bus_error  <= 1'b1;
              error_addr <= cpu_addr;
            end else begin
              state  <= ACCESS;
              idx_q  <= hit_idx;
              cnt    <= '0;
              tgt_cs <= NUM_TARGETS'(1) << hit_idx;
            end
          end
        end

        ACCESS: begin
          if (tgt_ready[idx_q]) begin
            state     <= RESP;
            tgt_cs    <= '0;
            cpu_ready <= 1'b1;
            cpu_rdata <= tgt_rdata[idx_q*32 +: 32];
          end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
            state      <= RESP;
            tgt_cs     <= '0;
            cpu_ready  <= 1'b1;
            cpu_rdata  <= ERR_DATA;
            bus_error  <= 1'b1;
            error_addr <= addr_q;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mmio_bus_fabric.md
Name: mmio_bus_fabric

Overview:
- Parametrised successor to the top-level CPU memory decode/mux.
- Sits between the picorv32 native memory port and N memory-mapped targets.
- Decodes a configurable address prefix per target, drives chip-select, and holds it until the target's ready.
- Returns registered read data, supports a forced-trap override, and bounds every access with a timeout that reports a sticky bus error with the faulting address.

Parameters:
- NUM_TARGETS, 8, number of target slots (1..16).
- PREFIX_WIDTH, 8, number of upper address bits compared, cpu_addr[31 -: PREFIX_WIDTH].
- TARGET_PREFIXES, {8{8'h00}}, packed NUM_TARGETS*PREFIX_WIDTH vector; slot i uses bits [i*PREFIX_WIDTH +: PREFIX_WIDTH].
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before abort; 0 disables the timeout.
- ERR_DATA, 32'hdeadbeef, rdata returned on a timeout.
- TRAP_DATA, 32'h0, rdata returned while force_trap is high (illegal instruction).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_valid  in  1  CPU request valid; held until cpu_ready
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_wstrb  in  4  byte write strobes; 0 means read
- cpu_ready  out  1  registered one-cycle completion pulse
- cpu_rdata  out  32  registered read data, valid while cpu_ready
- force_trap  in  1  substitute TRAP_DATA for any new access
- tgt_cs  out  NUM_TARGETS  one-hot chip-select
- tgt_we  out  4  latched strobes, qualified by tgt_cs
- tgt_addr  out  24  latched cpu_addr[23:0]
- tgt_wdata  out  32  latched write data
- tgt_rdata  in  NUM_TARGETS*32  per-target read data
- tgt_ready  in  NUM_TARGETS  per-target ready
- error_clear  in  1  clears bus_error
- bus_error  out  1  sticky timeout/unmapped flag
- error_addr  out  32  address of the most recent error

Behaviour:
- Reset: state=IDLE. All of the following are 0: tgt_cs, cpu_ready, cpu_rdata, bus_error, error_addr, the timeout counter, and latched addr/data/strobes.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: when cpu_valid=1 and cpu_ready=0, latch addr, wdata, and wstrb, then decode. Slot i matches when its prefix equals cpu_addr[31 -: PREFIX_WIDTH]; the lowest matching index wins.
  - force_trap=1 -> RESP with rdata=TRAP_DATA. force_trap has priority over decode.
  - No slot matches -> RESP with rdata=0; set bus_error and capture error_addr.
  - Otherwise -> ACCESS with the winning index latched and counter=0.
- ACCESS: tgt_cs[idx]=1 every cycle; tgt_we, tgt_addr, and tgt_wdata come from the latches.
  - tgt_ready[idx]=1 -> capture tgt_rdata[idx*32 +: 32] into cpu_rdata and go to RESP.
  - Else, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 -> cpu_rdata=ERR_DATA, set bus_error, error_addr=latched addr, go to RESP.
  - Else increment the counter. Its width is enough for TIMEOUT_CYCLES and it never wraps.
  - Ready from non-selected targets is ignored.
- RESP: cpu_ready=1 for exactly one cycle, then IDLE and cpu_ready=0. A request present in that IDLE cycle is accepted normally.
- Latency: a target with same-cycle ready gives cpu_ready 2 cycles after the cycle cpu_valid is first sampled. The trap and unmapped paths take 1 cycle.
- tgt_cs is 0 in IDLE and RESP, and is never multi-hot.
- cpu_valid dropping mid-ACCESS (protocol violation): the access still completes and the ready pulse is still issued.
- error_clear and a new error in the same cycle: the set wins, and error_addr takes the new address.
- force_trap changing mid-ACCESS has no effect on the in-flight access.
- reset mid-ACCESS: tgt_cs drops the next cycle, no cpu_ready is issued, and bus_error clears.

Test Plan:
- Slot 2 with prefix 8'hc3; read at 0xc300_0010; tgt_ready[2] asserted 3 cycles after cs -> tgt_cs=8'b0000_0100 for 4 cycles, tgt_addr=0x000010, cpu_ready one pulse carrying tgt_rdata slot 2 (0x1234_5678).
- Write 0xa5a5_a5a5 with wstrb=4'b0011 to slot 0, ready on the first cycle -> tgt_we=4'b0011 and tgt_wdata as written; cpu_ready exactly 2 cycles after valid.
- TIMEOUT_CYCLES=4, target never ready -> cs high for exactly 4 cycles, then cpu_rdata=0xdeadbeef, bus_error=1, error_addr=request address; error_clear pulse -> bus_error=0.
- Unmapped prefix 8'h80 -> no tgt_cs, cpu_ready after 1 cycle with rdata=0, bus_error=1, error_addr=0x8000_0000.
- force_trap=1 with a valid request to a mapped slot -> no tgt_cs, cpu_rdata=0x0, cpu_ready pulse after 1 cycle.
- Two slots with the same prefix 8'h10 -> only the lower index is selected. reset asserted during ACCESS -> tgt_cs=0 the next cycle, no cpu_ready, state returns to IDLE.
